// File: rtl/uart_rx_ctrl_pkg.sv
// uart_pkg: shared UART state encoding and bit-timing derivation for RX and TX controllers
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int CLK_FREQ_DEF = 100000000;
    localparam int BAUD_DEF     = 9600;

    function automatic int bit_tmr_max(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int half_tmr(input int clk_freq, input int baud);
        return bit_tmr_max(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: received-byte handshake and status from the UART receiver to the fabric
interface uart_rx_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       rx_busy;

    modport master (
        output rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy,
        input  rx_ack
    );

    modport slave (
        input  rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_ctrl_sync.sv
// uart_rx_sync: two-flop synchroniser on the serial line plus a history flop for start-edge detection
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    output logic rxd_s,
    output logic fall_edge
);
    logic s1;
    logic hist;

    // Resetting to 1 makes the line read idle, so no false start edge after reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {s1, rxd_s, hist} <= 3'b111;
        else        {s1, rxd_s, hist} <= {rxd, s1, rxd_s};

    assign fall_edge = hist & ~rxd_s;
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver with mid-bit sampling and a valid/ack byte handoff
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEF,
    parameter int BAUD     = BAUD_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           UART_RXD,
    uart_rx_ctrl_if.master bus
);
    localparam int BIT_TMR_MAX = bit_tmr_max(CLK_FREQ, BAUD);
    localparam int HALF_TMR    = half_tmr(CLK_FREQ, BAUD);
    localparam int TW          = $clog2(BIT_TMR_MAX);

    uart_state_e state, state_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic [7:0]    data_q;
    logic          valid_q, ovr_q, ferr_q;
    logic          deliver, ferr;
    logic          rxd_s, fall_edge;
    logic          tick_half, tick_bit;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (UART_RXD),
        .rxd_s    (rxd_s),
        .fall_edge(fall_edge)
    );

    assign tick_half = tmr == TW'(HALF_TMR - 1);
    assign tick_bit  = tmr == TW'(BIT_TMR_MAX - 1);

    always_comb begin
        state_n = state;
        tmr_n   = tmr + 1'b1;
        idx_n   = idx;
        sh_n    = sh;
        deliver = 1'b0;
        ferr    = 1'b0;
        case (state)
            IDLE: begin
                tmr_n   = '0;
                state_n = fall_edge ? START : IDLE;
            end
            START: if (tick_half) begin
                tmr_n   = '0;
                idx_n   = '0;
                state_n = rxd_s ? IDLE : DATA;
            end
            DATA: if (tick_bit) begin
                tmr_n      = '0;
                sh_n[idx]  = rxd_s;
                idx_n      = idx + 3'd1;
                state_n    = (idx == 3'd7) ? STOP : DATA;
            end
            // Leave mid-stop-bit so a back-to-back start edge is not missed
            STOP: if (tick_bit) begin
                tmr_n   = '0;
                state_n = IDLE;
                deliver = rxd_s;
                ferr    = ~rxd_s;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            tmr     <= '0;
            idx     <= '0;
            sh      <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            tmr     <= tmr_n;
            idx     <= idx_n;
            sh      <= sh_n;
            data_q  <= deliver ? sh : data_q;
            valid_q <= deliver | (valid_q & ~bus.rx_ack);
            ovr_q   <= deliver & valid_q & ~bus.rx_ack;
            ferr_q  <= ferr;
        end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_overrun   = ovr_q;
    assign bus.rx_frame_err = ferr_q;
    assign bus.rx_busy      = state != IDLE;
endmodule
